// File: rtl/upsample2x_layer_pkg.sv
// -----------------------------------------------------------------------------
// upsample2x_layer_pkg
// Shared definitions for the 2x streaming upsampler: default pixel width,
// the row-state encoding of the upsampler FSM and a counter-width helper.
// -----------------------------------------------------------------------------
package upsample2x_layer_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;

    // ROW_A: even output row (accept + emit twice), ROW_B: odd output row (replay)
    typedef enum logic {
        ROW_A = 1'b0,
        ROW_B = 1'b1
    } row_state_e;

    // Counter width for a range of n values; never collapses to zero bits.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/upsample_line_buf.sv
// -----------------------------------------------------------------------------
// upsample_line_buf
// Single-port synchronous RAM holding one input row. A write and a read never
// occur in the same cycle; dout reflects the word at the address presented on
// the previous clock edge.
// Ports:
//   clk   in   rising-edge clock
//   we    in   write enable
//   addr  in   word address (column)
//   din   in   write data
//   dout  out  registered read data
// -----------------------------------------------------------------------------
module upsample_line_buf #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] dout_r;

    // Storage array: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        dout_r <= mem_r[addr];
    end

    assign dout = dout_r;

endmodule

// File: rtl/upsample2x_layer.sv
// -----------------------------------------------------------------------------
// upsample2x_layer
// Streaming 2x spatial upsampler. An IMG_WIDTH x IMG_HEIGHT raster of signed
// pixels becomes a 2*IMG_WIDTH x 2*IMG_HEIGHT raster, one output per clock.
// Each input row produces an even output row (every pixel emitted twice while
// it is stored in the line buffer) and an odd output row replayed from the
// line buffer. The input is throttled through ready_in.
//
// Optional build macro UPSAMPLE_ZERO_INSERT_EN: zero-insertion mode (front
// half of a stride-2 transposed conv). Each pixel is followed by a zero and
// the odd rows are all zeros; line-buffer writes are suppressed. Timing and
// handshakes are unchanged.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   valid_in    in   data_in valid (consumed on valid_in && ready_in)
//   data_in     in   input pixel, raster order
//   ready_in    out  block accepts a pixel this cycle (registered)
//   valid_out   out  data_out valid (registered)
//   data_out    out  output pixel, raster order (registered)
//   frame_done  out  one-cycle pulse with the last output pixel of a frame
// -----------------------------------------------------------------------------
module upsample2x_layer
    import upsample2x_layer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);

    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

`ifdef UPSAMPLE_ZERO_INSERT_EN
    localparam logic ZERO_INSERT = 1'b1;
`else
    localparam logic ZERO_INSERT = 1'b0;
`endif

    row_state_e            state_r;
    logic                  phase_r;
    logic [COL_W-1:0]      col_r;
    logic [ROW_W-1:0]      row_r;
    logic                  ready_r;
    logic                  valid_out_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  frame_done_r;

    logic                  accept_s;
    logic                  lb_we_s;
    logic [COL_W-1:0]      lb_addr_s;
    logic [DATA_WIDTH-1:0] lb_dout_s;
    logic [DATA_WIDTH-1:0] replay_s;

    // ready_r is only ever set for ROW_A phase 0, so it fully qualifies a transfer.
    assign accept_s = valid_in & ready_r;

    // Line-buffer address/write control. The read address runs one step ahead
    // of the replay position so the synchronous read lands just in time; the
    // last ROW_A cycle prefetches column 0 so ROW_B starts without a bubble.
    always_comb begin
        lb_we_s   = 1'b0;
        lb_addr_s = col_r;
        replay_s  = ZERO_INSERT ? {DATA_WIDTH{1'b0}} : lb_dout_s;
        if (state_r == ROW_A) begin
            if (phase_r == 1'b0) begin
                lb_we_s   = accept_s & ~ZERO_INSERT;
                lb_addr_s = col_r;
            end else begin
                lb_we_s   = 1'b0;
                lb_addr_s = (col_r == COL_LAST) ? COL_ZERO : col_r;
            end
        end else begin
            lb_we_s = 1'b0;
            if (phase_r == 1'b1) begin
                lb_addr_s = (col_r == COL_LAST) ? COL_ZERO : (col_r + COL_ONE);
            end else begin
                lb_addr_s = col_r;
            end
        end
    end

    upsample_line_buf #(
        .DEPTH      (IMG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (COL_W)
    ) u_line_buf (
        .clk  (clk),
        .we   (lb_we_s),
        .addr (lb_addr_s),
        .din  (data_in),
        .dout (lb_dout_s)
    );

    // Row FSM, col/row/phase counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ROW_A;
            phase_r      <= 1'b0;
            col_r        <= COL_ZERO;
            row_r        <= ROW_ZERO;
            ready_r      <= 1'b0;
            valid_out_r  <= 1'b0;
            data_out_r   <= {DATA_WIDTH{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            case (state_r)
                ROW_A: begin
                    frame_done_r <= 1'b0;
                    if (phase_r == 1'b0) begin
                        if (accept_s) begin
                            data_out_r  <= data_in;
                            valid_out_r <= 1'b1;
                            phase_r     <= 1'b1;
                            ready_r     <= 1'b0;
                        end else begin
                            valid_out_r <= 1'b0;
                            ready_r     <= 1'b1;
                        end
                    end else begin
                        // Second emit: repeat the held pixel, or a zero when inserting.
                        data_out_r  <= ZERO_INSERT ? {DATA_WIDTH{1'b0}} : data_out_r;
                        valid_out_r <= 1'b1;
                        phase_r     <= 1'b0;
                        if (col_r == COL_LAST) begin
                            state_r <= ROW_B;
                            col_r   <= COL_ZERO;
                            ready_r <= 1'b0;
                        end else begin
                            col_r   <= col_r + COL_ONE;
                            ready_r <= 1'b1;
                        end
                    end
                end
                ROW_B: begin
                    data_out_r  <= replay_s;
                    valid_out_r <= 1'b1;
                    if (phase_r == 1'b0) begin
                        phase_r      <= 1'b1;
                        ready_r      <= 1'b0;
                        frame_done_r <= 1'b0;
                    end else begin
                        phase_r <= 1'b0;
                        if (col_r == COL_LAST) begin
                            // Raise ready_r now so the next row is accepted with no gap.
                            state_r <= ROW_A;
                            col_r   <= COL_ZERO;
                            ready_r <= 1'b1;
                            if (row_r == ROW_LAST) begin
                                row_r        <= ROW_ZERO;
                                frame_done_r <= 1'b1;
                            end else begin
                                row_r        <= row_r + ROW_ONE;
                                frame_done_r <= 1'b0;
                            end
                        end else begin
                            col_r        <= col_r + COL_ONE;
                            ready_r      <= 1'b0;
                            frame_done_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r      <= ROW_A;
                    phase_r      <= 1'b0;
                    col_r        <= COL_ZERO;
                    row_r        <= ROW_ZERO;
                    ready_r      <= 1'b0;
                    valid_out_r  <= 1'b0;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready_in   = ready_r;
    assign valid_out  = valid_out_r;
    assign data_out   = data_out_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_upsample2x_layer.sv
// -----------------------------------------------------------------------------
// tb_upsample2x_layer
// Directed self-checking bench for upsample2x_layer with a 4x2 input frame.
// Outputs are captured on the falling edge into queues (value, frame_done,
// ready_in, cycle stamp) and each test compares them with hand-written tables.
// -----------------------------------------------------------------------------
module tb_upsample2x_layer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [15:0] data_in;
    logic        ready_in;
    logic        valid_out;
    logic [15:0] data_out;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int drive_timeouts = 0;
    int cyc = 0;

    logic [15:0] out_q [$];
    logic        fd_q  [$];
    logic        rdy_q [$];
    int          cyc_q [$];

    // Frame 1..8: even rows emit each pixel twice, odd rows repeat the even row.
    logic [15:0] vals1 [32];
    logic [15:0] exp1  [32];
    logic        exp_rdy [16];
    logic [15:0] vals4 [32];
    logic [15:0] exp4  [32];
    logic [15:0] exp6  [16];

    upsample2x_layer #(
        .DATA_WIDTH (16),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            out_q.push_back(data_out);
            fd_q.push_back(frame_done);
            rdy_q.push_back(ready_in);
            cyc_q.push_back(cyc);
        end
    end

    task automatic clear_capture();
        out_q.delete();
        fd_q.delete();
        rdy_q.delete();
        cyc_q.delete();
    endtask

    // Called at a falling edge; returns at a falling edge after the last transfer.
    task automatic drive_pixels(input logic [15:0] vals [32], input int n,
                                input int stall_after, input int stall_len);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            valid_in = 1'b1;
            data_in  = vals[i];
            while (ready_in !== 1'b1 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                drive_timeouts++;
                valid_in = 1'b0;
                return;
            end
            @(negedge clk);
            valid_in = 1'b0;
            if (i == stall_after) repeat (stall_len + 1) @(negedge clk);
        end
    endtask

    task automatic wait_outputs(input int n);
        int w;
        w = 0;
        while (out_q.size() < n && w < 300) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b0;
        data_in = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if (ready_in !== 1'b0 || valid_out !== 1'b0 || data_out !== 16'h0000 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b data=%h fd=%b, expected 0 0 0000 0",
                     ready_in, valid_out, data_out, frame_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b valid=%b, expected 1 0", ready_in, valid_out);
        end
    endtask

    task automatic test_continuous();
        clear_capture();
        drive_pixels(vals1, 8, -1, 0);
        wait_outputs(32);
        checks++;
        if (out_q.size() !== 32 || drive_timeouts !== 0) begin
            errors++;
            $display("FAIL t1_count: got %0d outputs (timeouts %0d), expected 32", out_q.size(), drive_timeouts);
        end
        for (int i = 0; i < 32 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp1[i]) begin
                errors++;
                $display("FAIL t1_data[%0d]: got %0d expected %0d", i, out_q[i], exp1[i]);
            end
            checks++;
            if (fd_q[i] !== (i == 31)) begin
                errors++;
                $display("FAIL t1_frame_done[%0d]: got %b expected %b", i, fd_q[i], (i == 31));
            end
        end
    endtask

    task automatic test_handshake();
        clear_capture();
        drive_pixels(vals1, 8, -1, 0);
        wait_outputs(32);
        checks++;
        if (out_q.size() !== 32) begin
            errors++;
            $display("FAIL t2_count: got %0d expected 32", out_q.size());
        end
        for (int i = 0; i < 32 && i < out_q.size(); i++) begin
            checks++;
            if (rdy_q[i] !== exp_rdy[i % 16]) begin
                errors++;
                $display("FAIL t2_ready[%0d]: got %b expected %b", i, rdy_q[i], exp_rdy[i % 16]);
            end
            if (i > 0) begin
                checks++;
                if (cyc_q[i] - cyc_q[i-1] !== 1) begin
                    errors++;
                    $display("FAIL t2_valid_gap[%0d]: got spacing %0d expected 1", i, cyc_q[i] - cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        clear_capture();
        drive_pixels(vals1, 8, 1, 3);
        wait_outputs(32);
        checks++;
        if (out_q.size() !== 32) begin
            errors++;
            $display("FAIL t3_count: got %0d expected 32", out_q.size());
        end
        for (int i = 0; i < 32 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp1[i]) begin
                errors++;
                $display("FAIL t3_data[%0d]: got %0d expected %0d", i, out_q[i], exp1[i]);
            end
            if (i > 0) begin
                checks++;
                if (cyc_q[i] - cyc_q[i-1] !== ((i == 4) ? 4 : 1)) begin
                    errors++;
                    $display("FAIL t3_spacing[%0d]: got %0d expected %0d", i,
                             cyc_q[i] - cyc_q[i-1], (i == 4) ? 4 : 1);
                end
            end
        end
    endtask

    task automatic test_signed();
        clear_capture();
        drive_pixels(vals4, 8, -1, 0);
        wait_outputs(32);
        checks++;
        if (out_q.size() !== 32) begin
            errors++;
            $display("FAIL t4_count: got %0d expected 32", out_q.size());
        end
        for (int i = 0; i < 32 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp4[i]) begin
                errors++;
                $display("FAIL t4_data[%0d]: got %0d expected %0d", i, $signed(out_q[i]), $signed(exp4[i]));
            end
        end
    endtask

    task automatic test_reset_mid_row_b();
        clear_capture();
        drive_pixels(vals1, 4, -1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0 || data_out !== 16'h0000 || ready_in !== 1'b0) begin
                errors++;
                $display("FAIL t5_in_reset[%0d]: got valid=%b data=%h ready=%b expected 0 0000 0",
                         k, valid_out, data_out, ready_in);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_capture();
        drive_pixels(vals1, 8, -1, 0);
        wait_outputs(32);
        checks++;
        if (out_q.size() !== 32) begin
            errors++;
            $display("FAIL t5_count: got %0d expected 32", out_q.size());
        end
        for (int i = 0; i < 32 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp1[i] || fd_q[i] !== (i == 31)) begin
                errors++;
                $display("FAIL t5_data[%0d]: got %0d/fd=%b expected %0d/fd=%b",
                         i, out_q[i], fd_q[i], exp1[i], (i == 31));
            end
        end
    endtask

    task automatic test_zero_insert();
        clear_capture();
        drive_pixels(vals1, 4, -1, 0);
        wait_outputs(16);
        checks++;
        if (out_q.size() !== 16) begin
            errors++;
            $display("FAIL t6_count: got %0d expected 16", out_q.size());
        end
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp6[i]) begin
                errors++;
                $display("FAIL t6_data[%0d]: got %0d expected %0d", i, out_q[i], exp6[i]);
            end
        end
    endtask

    initial begin
        vals1 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
                  16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                  16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                  16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        exp1  = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4, 16'd4,
                  16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4, 16'd4,
                  16'd5, 16'd5, 16'd6, 16'd6, 16'd7, 16'd7, 16'd8, 16'd8,
                  16'd5, 16'd5, 16'd6, 16'd6, 16'd7, 16'd7, 16'd8, 16'd8};
        // ready_in seen alongside each output of one input row (even + odd output row)
        exp_rdy = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vals4 = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        exp4  = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                  16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                  16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000,
                  16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
        exp6  = '{16'd1, 16'd0, 16'd2, 16'd0, 16'd3, 16'd0, 16'd4, 16'd0,
                  16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = 16'h0000;
        @(negedge clk);
        test_reset();
`ifdef UPSAMPLE_ZERO_INSERT_EN
        test_zero_insert();
`else
        test_continuous();
        test_handshake();
        test_stall();
        test_signed();
        test_reset_mid_row_b();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
